// File: rtl/servo_cmd_uart_tx.sv
// servo_cmd_uart_tx: wraps a BCD servo angle into "#<ID>P<dddd>T<tttt>!" and sends it as 8N1 UART.
// Optional: define SERVO_CMD_CRLF_EN to append CR LF after '!'. DIV = CLK_FREQ/BAUD must be >= 2.
module servo_cmd_uart_tx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int SERVO_ID     = 0,
  parameter int MOVE_TIME_MS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] angle_bcd,
  input  logic        send,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV);

`ifdef SERVO_CMD_CRLF_EN
  localparam int NBYTES = 17;
`else
  localparam int NBYTES = 15;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [4:0]       BYTE_LAST = 5'(NBYTES - 1);

  // Fixed ID and move-time digits are resolved to ASCII at elaboration.
  localparam logic [7:0] ID2 = 8'(48 + (SERVO_ID / 100) % 10);
  localparam logic [7:0] ID1 = 8'(48 + (SERVO_ID / 10) % 10);
  localparam logic [7:0] ID0 = 8'(48 + SERVO_ID % 10);
  localparam logic [7:0] T3  = 8'(48 + (MOVE_TIME_MS / 1000) % 10);
  localparam logic [7:0] T2  = 8'(48 + (MOVE_TIME_MS / 100) % 10);
  localparam logic [7:0] T1  = 8'(48 + (MOVE_TIME_MS / 10) % 10);
  localparam logic [7:0] T0  = 8'(48 + MOVE_TIME_MS % 10);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [4:0]       byte_q, byte_d;
  logic [15:0]      angle_q;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept;
  logic             bit_end;
  logic [7:0]       cur_byte;

  function automatic logic bcd_ok(input logic [15:0] v);
    return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) &&
           (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [4:0] idx, input logic [15:0] a);
    logic [7:0] b;
    case (idx)
      5'd0:    b = 8'h23;
      5'd1:    b = ID2;
      5'd2:    b = ID1;
      5'd3:    b = ID0;
      5'd4:    b = 8'h50;
      5'd5:    b = digit_char(a[15:12]);
      5'd6:    b = digit_char(a[11:8]);
      5'd7:    b = digit_char(a[7:4]);
      5'd8:    b = digit_char(a[3:0]);
      5'd9:    b = 8'h54;
      5'd10:   b = T3;
      5'd11:   b = T2;
      5'd12:   b = T1;
      5'd13:   b = T0;
      5'd14:   b = 8'h21;
`ifdef SERVO_CMD_CRLF_EN
      5'd15:   b = 8'h0D;
      5'd16:   b = 8'h0A;
`endif
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  assign bit_end = (cnt_q == CNT_LAST);
  assign accept  = (state_q == S_IDLE) && send && !busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bcd_ok(angle_bcd)) begin
            state_d = S_START;
            cnt_d   = '0;
            bit_d   = '0;
            byte_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (byte_q == BYTE_LAST) begin
            state_d = S_DONE;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = S_START;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Line outputs are decoded from the next state so tx/busy/done come straight off flops.
    cur_byte = frame_byte(byte_d, angle_q);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Angle holding register is data only; it is first read one bit period after the load.
  always_ff @(posedge clk) begin
    if (accept) begin
      angle_q <= angle_bcd;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_servo_cmd_uart_tx.sv
// Directed bench for servo_cmd_uart_tx: decodes the serial line from a per-cycle log and
// compares against hand-written command strings (two instances cover both ID/time settings).
`timescale 1ns/1ps
module tb_servo_cmd_uart_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = 10;
`ifdef SERVO_CMD_CRLF_EN
  localparam int NB = 17;
`else
  localparam int NB = 15;
`endif
  localparam int FRAME_CYC = NB * 10 * DIV;
  localparam int LOGN      = FRAME_CYC + 20;
  localparam int NV        = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        send;
  logic [15:0] angle_bcd;
  logic        tx0, busy0, done0, err0;
  logic        tx1, busy1, done1, err1;

  int errors = 0;
  int checks = 0;

  logic tx_log   [LOGN];
  logic busy_log [LOGN];
  logic done_log [LOGN];
  logic err_log  [LOGN];

  typedef struct packed {
    logic              sel;
    logic [15:0]       angle;
    int                inj_cyc;
    logic [15:0]       inj_angle;
    logic              inj_send;
    logic              exp_err;
    logic [8*NB-1:0]   exp_frame;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  servo_cmd_uart_tx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .SERVO_ID(0), .MOVE_TIME_MS(1000)
  ) u_dut0 (
    .clk(clk), .rst(rst), .angle_bcd(angle_bcd), .send(send),
    .tx(tx0), .busy(busy0), .done(done0), .err(err0)
  );

  servo_cmd_uart_tx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .SERVO_ID(7), .MOVE_TIME_MS(250)
  ) u_dut1 (
    .clk(clk), .rst(rst), .angle_bcd(angle_bcd), .send(send),
    .tx(tx1), .busy(busy1), .done(done1), .err(err1)
  );

  function automatic logic [8*NB-1:0] mk(input logic [8*15-1:0] s);
`ifdef SERVO_CMD_CRLF_EN
    return {s, 8'h0D, 8'h0A};
`else
    return s;
`endif
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int nbusy, ndone, nerr, ntx0, first_idle, bad_frm;
    logic [7:0] got;
    nbusy = 0; ndone = 0; nerr = 0; ntx0 = 0; first_idle = -1; bad_frm = 0;
    @(negedge clk);
    angle_bcd = v.angle;
    send      = 1'b1;
    for (int c = 0; c < LOGN; c++) begin
      @(negedge clk);
      tx_log[c]   = v.sel ? tx1   : tx0;
      busy_log[c] = v.sel ? busy1 : busy0;
      done_log[c] = v.sel ? done1 : done0;
      err_log[c]  = v.sel ? err1  : err0;
      if (c == 0) send = 1'b0;
      if (c == v.inj_cyc) begin
        angle_bcd = v.inj_angle;
        send      = v.inj_send;
      end else if (c == v.inj_cyc + 1) begin
        send = 1'b0;
      end
    end
    send = 1'b0;
    for (int c = 0; c < LOGN; c++) begin
      if (busy_log[c] === 1'b1) nbusy++;
      if (done_log[c] === 1'b1) ndone++;
      if (err_log[c] === 1'b1) nerr++;
      if (tx_log[c] !== 1'b1) ntx0++;
      if (first_idle < 0 && busy_log[c] !== 1'b1) first_idle = c;
    end
    if (v.exp_err) begin
      check({name, " err_pulses"}, nerr, 1);
      check({name, " err_first_cycle"}, int'(err_log[0]), 1);
      check({name, " tx_low_cycles"}, ntx0, 0);
      check({name, " busy_cycles"}, nbusy, 0);
      check({name, " done_pulses"}, ndone, 0);
    end else begin
      check({name, " err_pulses"}, nerr, 0);
      check({name, " busy_cycles"}, nbusy, FRAME_CYC);
      check({name, " busy_first_low"}, first_idle, FRAME_CYC);
      check({name, " done_pulses"}, ndone, 1);
      check({name, " done_cycle"}, int'(done_log[FRAME_CYC]), 1);
      for (int b = 0; b < NB; b++) begin
        int base;
        base = b * 10 * DIV + DIV / 2;
        if (tx_log[base] !== 1'b0) bad_frm++;
        if (tx_log[base + 9 * DIV] !== 1'b1) bad_frm++;
        for (int j = 0; j < 8; j++) got[j] = tx_log[base + (j + 1) * DIV];
        check($sformatf("%s byte%0d", name, b), int'(got),
              int'(v.exp_frame[8 * (NB - 1 - b) +: 8]));
      end
      check({name, " start_stop_errors"}, bad_frm, 0);
    end
  endtask

  initial begin
    int nd, nb, cnt;
    vecs[0] = '{1'b0, 16'h1500, -1, 16'h0000, 1'b0, 1'b0, mk("#000P1500T1000!")};
    vecs[1] = '{1'b1, 16'h2499, -1, 16'h0000, 1'b0, 1'b0, mk("#007P2499T0250!")};
    vecs[2] = '{1'b0, 16'h15A0, -1, 16'h0000, 1'b0, 1'b1, mk(120'd0)};
    vecs[3] = '{1'b0, 16'h1500, 200, 16'h0900, 1'b1, 1'b0, mk("#000P1500T1000!")};
    vecs[4] = '{1'b0, 16'h0387, 300, 16'h9999, 1'b0, 1'b0, mk("#000P0387T1000!")};
    vecs[5] = '{1'b0, 16'h9000, FRAME_CYC, 16'h1111, 1'b1, 1'b0, mk("#000P9000T1000!")};
    vecs[6] = '{1'b1, 16'hF000, -1, 16'h0000, 1'b0, 1'b1, mk(120'd0)};
    vecs[7] = '{1'b0, 16'h0009, -1, 16'h0000, 1'b0, 1'b0, mk("#000P0009T1000!")};
    vecs[8] = '{1'b1, 16'h000A, -1, 16'h0000, 1'b0, 1'b1, mk(120'd0)};

    rst       = 1'b1;
    send      = 1'b0;
    angle_bcd = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset tx0", int'(tx0), 1);
    check("reset busy0", int'(busy0), 0);
    check("reset done0", int'(done0), 0);
    check("reset err0", int'(err0), 0);
    check("reset tx1", int'(tx1), 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted during a data bit of the first byte.
    @(negedge clk);
    angle_bcd = 16'h1500;
    send      = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("rst_mid pre busy", int'(busy0), 1);
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid tx", int'(tx0), 1);
    check("rst_mid busy", int'(busy0), 0);
    rst = 1'b0;
    nd = 0; nb = 0;
    repeat (FRAME_CYC) begin
      @(negedge clk);
      if (done0 === 1'b1) nd++;
      if (busy0 === 1'b1) nb++;
    end
    check("rst_mid no_done", nd, 0);
    check("rst_mid stays_idle", nb, 0);
    run_vec(vecs[0], "after_reset");

    // Earliest re-accept is the cycle after done.
    @(negedge clk);
    angle_bcd = 16'h0042;
    send      = 1'b1;
    @(negedge clk);
    send = 1'b0;
    cnt  = 0;
    while (done0 !== 1'b1 && cnt < FRAME_CYC + 50) begin
      @(negedge clk);
      cnt++;
    end
    check("reaccept done_index", cnt, FRAME_CYC);
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("reaccept busy", int'(busy0), 1);
    check("reaccept tx_start", int'(tx0), 0);
    repeat (FRAME_CYC + 5) @(negedge clk);
    check("reaccept idle_after", int'(busy0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
